dest_port_fifo: RTL and testbench
=================================

Name: dest_port_fifo

Overview:
- Parametrised destination-side output buffer for the router: one instance per output channel.
- Sits between the router core (write side) and the destination agent (read side).
- Read side uses the established valid_out / read_en / data_out handshake.
- Adds depth/width generalisation, packet-boundary tracking from the header byte, and a stall-timeout soft reset that flushes the channel.

Parameters:
- DATA_W, 8, payload byte width (>=3; header length field is bits [DATA_W-1:2]).
- DEPTH, 16, FIFO entries; power of two, >=2.
- TIMEOUT, 30, consecutive stalled cycles before soft reset (>=2).

Ports:
- clk  input  1  clock, all logic on posedge.
- resetn  input  1  asynchronous active-low reset.
- write_en  input  1  write request from router core.
- lfd_state  input  1  marks current write as header byte.
- data_in  input  DATA_W  write data.
- read_en  input  1  destination pops head entry.
- data_out  output  DATA_W  head entry data; 0 when empty.
- valid_out  output  1  FIFO non-empty.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- soft_reset  output  1  one-cycle pulse on timeout flush.
- pkt_busy  output  1  packet partially drained (header popped, tail not yet popped).
- overflow  output  1  sticky dropped-write flag (see Optional Feature).

Behaviour:
- Reset (resetn=0, async): pointers, count, stall counter, and packet counter cleared.
  - data_out=0, valid_out=0, full=0, empty=1, soft_reset=0, pkt_busy=0, overflow=0.
- Storage: DEPTH x (DATA_W+1). Bit DATA_W holds lfd_state captured at write.
  - Pointers are log2(DEPTH)+1 bits; the MSB distinguishes full from empty; wrap-around is natural.
- Write accepted on posedge when write_en=1 and full=0. A write while full is dropped; the entry is unchanged.
- Read accepted on posedge when read_en=1 and valid_out=1. read_en while empty is ignored.
- Output timing:
  - data_out is the head entry combinationally (first-word-fall-through); valid_out = !empty.
  - A write to an empty FIFO appears on valid_out/data_out the cycle after the write edge.
- Simultaneous read+write:
  - Not full: both occur, count unchanged.
  - Full: read occurs, write dropped (full is evaluated pre-edge).
  - Empty: write only.
- Packet tracking:
  - Pop of an entry with header flag=1 loads pkt_remain = data[DATA_W-1:2] + 1 (payload bytes + parity byte) and sets pkt_busy=1.
  - Each subsequent pop decrements pkt_remain; pkt_busy clears on the pop that takes pkt_remain to 0.
  - A header popped while pkt_busy=1 reloads the counter (truncated packet, no error).
- Stall timeout:
  - stall_cnt increments each cycle valid_out=1 and read_en=0; clears on any accepted read or when empty.
  - When stall_cnt reaches TIMEOUT-1 with the stall still present, the next edge:
    - pulses soft_reset=1 for exactly one cycle;
    - resets pointers (FIFO empty), pkt_busy=0, stall_cnt=0.
    - overflow is not cleared.
  - A write on the flush edge is dropped.
  - A read_en on the flush edge is ignored; the flush wins.
- Asserting resetn mid-packet or mid-stall: immediate return to reset values; no soft_reset pulse.

Optional Feature:
- Macro: DEST_OVF_STATUS_EN.
- Defined:
  - overflow sets on any write_en=1 while full=1 and is sticky until resetn.
  - A 16-bit saturating counter ovf_cnt (internal, hierarchy-visible) counts dropped writes.
- Not defined: overflow tied to 0; no counter logic.

Test Plan:
- Reset then write 0x0C (lfd=1) plus payload 0x11,0x22,0x33 and parity 0x44; read continuously.
  - Expect data_out sequence 0x0C,0x11,0x22,0x33,0x44.
  - pkt_busy=1 after the header pop, clearing on the 0x44 pop.
  - valid_out=0 after.
- Write 16 bytes with read_en=0 (DEPTH=16) -> full=1 on the 16th write.
  - A 17th write (0xAA) is dropped; overflow=1 with the macro, 0 without.
  - Drain returns the original 16 bytes in order.
- Full FIFO, simultaneous read_en=1 and write_en=1 with 0x55 -> read occurs, write dropped, count becomes 15.
  - Repeat next cycle: both occur, count stays 15, 0x55 is last out.
- Write one byte, hold read_en=0 -> soft_reset=1 exactly one cycle when the stall count reaches 30 (TIMEOUT=30).
  - Then empty=1, valid_out=0, data_out=0.
  - Stall of 29 cycles followed by a read produces no soft_reset.
- Write/read 3*DEPTH bytes in a streaming pattern (incrementing 0x00..0x2F) -> pointer wrap-around with no loss or reorder.
- Deassert resetn for 1 cycle mid-packet with 5 entries stored -> all outputs return to reset values asynchronously and soft_reset stays 0.

Source files
------------

// File: rtl/dest_port_fifo.sv
// Destination-side output buffer: FWFT FIFO with header-driven packet tracking and stall-timeout flush.
// Optional sticky drop flag and drop counter enabled by DEST_OVF_STATUS_EN.
module dest_port_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              write_en,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              soft_reset,
    output logic              pkt_busy,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam int RW = DATA_W - 1;

    logic [DATA_W:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [SW-1:0]   stall_cnt;
    logic [RW-1:0]   pkt_remain;
    logic [DATA_W:0] head;
    logic            stall;
    logic            flush;
    logic            wr_accept;
    logic            rd_accept;

    assign head      = mem[rd_ptr[AW-1:0]];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid_out = !empty;
    assign data_out  = empty ? '0 : head[DATA_W-1:0];

    assign stall     = valid_out && !read_en;
    assign flush     = stall && (stall_cnt == SW'(TIMEOUT - 1));
    assign wr_accept = write_en && !full && !flush;
    assign rd_accept = read_en && valid_out && !flush;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            stall_cnt  <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= flush;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                stall_cnt <= '0;
            end else begin
                if (wr_accept) wr_ptr <= wr_ptr + PW'(1);
                if (rd_accept) rd_ptr <= rd_ptr + PW'(1);
                stall_cnt <= stall ? stall_cnt + SW'(1) : '0;
            end
        end
    end

    // Header length field counts payload bytes; the trailing parity byte adds one more pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_remain <= '0;
            pkt_busy   <= 1'b0;
        end else if (flush) begin
            pkt_remain <= '0;
            pkt_busy   <= 1'b0;
        end else if (rd_accept) begin
            if (head[DATA_W]) begin
                pkt_remain <= {1'b0, head[DATA_W-1:2]} + RW'(1);
                pkt_busy   <= 1'b1;
            end else if (pkt_busy) begin
                pkt_remain <= pkt_remain - RW'(1);
                if (pkt_remain == RW'(1)) pkt_busy <= 1'b0;
            end
        end
    end

`ifdef DEST_OVF_STATUS_EN
    logic        ovf_q;
    logic [15:0] ovf_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_q   <= 1'b0;
            ovf_cnt <= '0;
        end else if (write_en && full) begin
            ovf_q <= 1'b1;
            if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_dest_port_fifo.sv
// Self-checking bench for dest_port_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_dest_port_fifo;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;
`ifdef DEST_OVF_STATUS_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn;
    logic              write_en;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic              read_en;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              full;
    logic              empty;
    logic              soft_reset;
    logic              pkt_busy;
    logic              overflow;

    dest_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .write_en(write_en), .lfd_state(lfd_state),
        .data_in(data_in), .read_en(read_en), .data_out(data_out), .valid_out(valid_out),
        .full(full), .empty(empty), .soft_reset(soft_reset), .pkt_busy(pkt_busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W:0] q[$];
    int  stall_m;
    int  remain_m;
    bit  busy_m;
    bit  ovf_m;
    bit  sr_m;
    int  pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        stall_m  = 0;
        remain_m = 0;
        busy_m   = 0;
        ovf_m    = 0;
        sr_m     = 0;
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] exp_d;
        exp_d = (q.size() != 0) ? q[0][DATA_W-1:0] : '0;
        chk({tag, ".data_out"},   32'(data_out),   32'(exp_d));
        chk({tag, ".valid_out"},  32'(valid_out),  32'(q.size() != 0));
        chk({tag, ".full"},       32'(full),       32'(q.size() == DEPTH));
        chk({tag, ".empty"},      32'(empty),      32'(q.size() == 0));
        chk({tag, ".soft_reset"}, 32'(soft_reset), 32'(sr_m));
        chk({tag, ".pkt_busy"},   32'(pkt_busy),   32'(busy_m));
        chk({tag, ".overflow"},   32'(overflow),   32'(ovf_m));
    endtask

    task automatic cycle(input string tag, input logic we, input logic lfd,
                         input logic [DATA_W-1:0] din, input logic re);
        bit was_full, was_empty, stalled, flush;
        logic [DATA_W:0] e;
        write_en  = we;
        lfd_state = lfd;
        data_in   = din;
        read_en   = re;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        stalled   = !was_empty && !re;
        flush     = stalled && (stall_m == TIMEOUT - 1);
        if (OVF_EN && we && was_full) ovf_m = 1;
        sr_m = flush;
        if (flush) begin
            q.delete();
            busy_m   = 0;
            remain_m = 0;
            stall_m  = 0;
        end else begin
            if (re && !was_empty) begin
                e = q.pop_front();
                if (e[DATA_W]) begin
                    remain_m = int'(e[DATA_W-1:2]) + 1;
                    busy_m   = 1;
                end else if (busy_m) begin
                    remain_m--;
                    if (remain_m == 0) busy_m = 0;
                end
            end
            if (we && !was_full) q.push_back({lfd, din});
            stall_m = stalled ? stall_m + 1 : 0;
        end
        #1;
        if (soft_reset) pulses++;
        check_all(tag);
    endtask

    initial begin
        logic [DATA_W-1:0] pkt [5];
        logic [DATA_W-1:0] got;
        pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h44;

        resetn = 1'b0; write_en = 0; lfd_state = 0; data_in = '0; read_en = 0;
        model_reset();
        #12;
        check_all("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        // Packet write, then read continuously (reads overlap later writes)
        cycle("pkt_w0", 1, 1, pkt[0], 0);
        for (int i = 1; i < 5; i++) cycle("pkt_wr", 1, 0, pkt[i], 1);
        chk("pkt_busy_mid", 32'(pkt_busy), 32'd1);
        for (int i = 0; i < 2; i++) cycle("pkt_rd", 0, 0, '0, 1);
        chk("pkt_done_busy", 32'(pkt_busy), 32'd0);
        chk("pkt_done_valid", 32'(valid_out), 32'd0);

        // Fill, overflow attempt, drain in order
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1, 0, DATA_W'(8'h80 + i), 0);
        chk("fill_full", 32'(full), 32'd1);
        cycle("ovf_wr", 1, 0, 8'hAA, 0);
        chk("ovf_flag", 32'(overflow), 32'(OVF_EN));
        for (int i = 0; i < DEPTH; i++) begin
            got = data_out;
            chk("drain_order", 32'(got), 32'(8'h80 + i));
            cycle("drain", 0, 0, '0, 1);
        end

        // Full with simultaneous read/write
        for (int i = 0; i < DEPTH; i++) cycle("fill2", 1, 0, DATA_W'(i), 0);
        cycle("rw_full", 1, 0, 8'h55, 1);
        chk("rw_full_cnt_notfull", 32'(full), 32'd0);
        cycle("rw_nf", 1, 0, 8'h55, 1);
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (i == DEPTH - 2) chk("last_is_55", 32'(data_out), 32'h55);
            cycle("drain2", 0, 0, '0, 1);
        end

        // Stall timeout flush
        cycle("to_wr", 1, 0, 8'h5A, 0);
        pulses = 0;
        for (int i = 0; i < TIMEOUT + 5; i++) cycle("stall", 0, 0, '0, 0);
        chk("to_pulses", 32'(pulses), 32'd1);
        chk("to_empty", 32'(empty), 32'd1);

        // Stall just short of timeout, then read
        cycle("ns_wr", 1, 0, 8'h3C, 0);
        pulses = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) cycle("ns_stall", 0, 0, '0, 0);
        cycle("ns_rd", 0, 0, '0, 1);
        cycle("ns_idle", 0, 0, '0, 0);
        chk("ns_pulses", 32'(pulses), 32'd0);

        // Streaming across pointer wrap
        for (int i = 0; i < 3 * DEPTH; i++) cycle("stream", 1, 0, DATA_W'(i), i != 0);
        cycle("stream_tail", 0, 0, '0, 1);

        // Async reset mid-packet with 5 entries stored
        cycle("mr_h", 1, 1, 8'h10, 0);
        for (int i = 0; i < 5; i++) cycle("mr_w", 1, 0, DATA_W'(8'hE0 + i), 0);
        cycle("mr_pop", 0, 0, '0, 1);
        chk("mr_busy_pre", 32'(pkt_busy), 32'd1);
        #3 resetn = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1;
        check_all("async_rst_hold");
        resetn = 1'b1;
        cycle("post_rst", 0, 0, '0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++)
            cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                  DATA_W'($urandom), 1'($urandom_range(0, 2) != 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
